down_timer_ctrl: RTL

- Controller and sequencer for a parameterised down-counter datapath. Turns it into a programmable interval timer with start/stop/pause control, one-shot or auto-reload mode, a terminal-count pulse and a sticky done flag.
- Sits between the control logic that requests timed intervals and the down-counter core it owns.
- With load_val=15 and auto_reload=1 it reproduces mod-16 down-count behaviour.

---
 rtl/down_timer_pkg.sv | 13 +
 rtl/down_timer_ctrl_core.sv | 26 ++
 rtl/down_timer_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/down_timer_pkg.sv
// Shared definitions for the down_timer_ctrl block: default width and FSM states.
package down_timer_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/down_timer_ctrl_core.sv
// Loadable down-counter datapath owned by the timer controller.
// load beats en; zero flags a count of 0 so the controller can choose reload or finish.
module down_counter_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             zero
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // Count register: load, else decrement when enabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      q <= '0;
    else if (load) q <= d;
    else if (en)   q <= q - ONE;
  end

  assign zero = (q == '0);

endmodule

// File: rtl/down_timer_ctrl.sv
// Programmable interval timer: start/stop/pause sequencing around a down-counter,
// one-shot or auto-reload, registered terminal-count pulse and sticky done.
module down_timer_ctrl
  import down_timer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic [WIDTH-1:0] load_val,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state, state_nx;
  logic [WIDTH-1:0] reload_r;
  logic             mode_r;
  logic             ld, en, zero, latch;
  logic [WIDTH-1:0] d, q_nx;

  down_counter_core #(.WIDTH(WIDTH)) u_core (
    .clk  (clk),
    .rst  (rst),
    .load (ld),
    .en   (en),
    .d    (d),
    .q    (q),
    .zero (zero)
  );

  // Next state plus counter commands; q_nx tracks what the core will hold after the edge
  // so tc can be registered alongside it.
  always_comb begin
    state_nx = state;
    ld       = 1'b0;
    en       = 1'b0;
    d        = load_val;
    latch    = 1'b0;
    q_nx     = q;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (stop) begin
          state_nx = ST_IDLE;
        end else if (start) begin
          state_nx = ST_RUN;
          ld       = 1'b1;
          latch    = 1'b1;
          q_nx     = load_val;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_nx = ST_IDLE;
          ld       = 1'b1;
          d        = '0;
          q_nx     = '0;
        end else if (pause) begin
          state_nx = ST_HOLD;
        end else if (!zero) begin
          en       = 1'b1;
          q_nx     = q - ONE;
        end else if (mode_r) begin
          ld       = 1'b1;
          d        = reload_r;
          q_nx     = reload_r;
        end else begin
          state_nx = ST_DONE;
        end
      end
      ST_HOLD: begin
        // Leaving HOLD spends the exit edge without counting.
        if (stop) begin
          state_nx = ST_IDLE;
          ld       = 1'b1;
          d        = '0;
          q_nx     = '0;
        end else if (!pause) begin
          state_nx = ST_RUN;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // State, latched run parameters and registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      reload_r <= '0;
      mode_r   <= 1'b0;
      tc       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state <= state_nx;
      if (latch) begin
        reload_r <= load_val;
        mode_r   <= auto_reload;
      end
      tc   <= (state_nx == ST_RUN) && (q_nx == '0);
      busy <= (state_nx == ST_RUN) || (state_nx == ST_HOLD);
      done <= (state_nx == ST_DONE);
    end
  end

endmodule
